// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add MUL and restoring UDIV/SDIV/UMOD,
// one iteration per cycle, result returned on the register-file write port.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  srca,
  input  logic [XLEN-1:0]  srcb,
  input  logic [RADDR-1:0] rd_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [RADDR-1:0] wa3,
  output logic             we3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_UMOD = 2'b11;

  // Two's-complement magnitude; the most negative value maps onto itself as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    mag = v[XLEN-1] ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    neg = ~v + XLEN'(1);
  endfunction

  state_t           state_r;
  logic [4:0]       count_r;
  logic [1:0]       op_r;
  logic [XLEN-1:0]  a_r;    // multiplicand / dividend-quotient shift register
  logic [XLEN-1:0]  b_r;    // multiplier / divisor
  logic [XLEN-1:0]  acc_r;  // product accumulator / partial remainder
  logic             neg_r;
  logic [RADDR-1:0] rd_r;
  logic             busy_r;
  logic             done_r;
  logic [XLEN-1:0]  result_r;
  logic [RADDR-1:0] wa3_r;

  logic [XLEN:0]    rem_w_s;
  logic [XLEN-1:0]  step_a_s;
  logic [XLEN-1:0]  step_b_s;
  logic [XLEN-1:0]  step_acc_s;
  logic [XLEN-1:0]  final_s;
  logic             div0_s;

  // One shift-add or restoring-division iteration on the current datapath state.
  always_comb begin
    rem_w_s    = {acc_r, a_r[XLEN-1]};
    step_a_s   = a_r;
    step_b_s   = b_r;
    step_acc_s = acc_r;
    if (op_r == OP_MUL) begin
      if (b_r[0]) begin
        step_acc_s = acc_r + a_r;
      end else begin
        step_acc_s = acc_r;
      end
      step_a_s = a_r << 1;
      step_b_s = b_r >> 1;
    end else begin
      step_b_s = b_r;
      if (rem_w_s >= {1'b0, b_r}) begin
        step_acc_s = rem_w_s[XLEN-1:0] - b_r;
        step_a_s   = {a_r[XLEN-2:0], 1'b1};
      end else begin
        step_acc_s = rem_w_s[XLEN-1:0];
        step_a_s   = {a_r[XLEN-2:0], 1'b0};
      end
    end
  end

  // Final result selection, including the signed-quotient fix-up.
  always_comb begin
    final_s = acc_r;
    case (op_r)
      OP_MUL:  final_s = acc_r;
      OP_UDIV: final_s = a_r;
      OP_SDIV: final_s = neg_r ? neg(a_r) : a_r;
      OP_UMOD: final_s = acc_r;
      default: final_s = acc_r;
    endcase
  end

  // Divide-by-zero detection at latch time.
  always_comb begin
    if ((op != OP_MUL) && (srcb == '0)) begin
      div0_s = 1'b1;
    end else begin
      div0_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= 5'd0;
      op_r     <= 2'b00;
      a_r      <= '0;
      b_r      <= '0;
      acc_r    <= '0;
      neg_r    <= 1'b0;
      rd_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      wa3_r    <= '0;
    end else begin
      done_r <= 1'b0;
      if (flush) begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              op_r    <= op;
              rd_r    <= rd_in;
              count_r <= 5'd31;
              busy_r  <= 1'b1;
              neg_r   <= (op == OP_SDIV) ? (srca[XLEN-1] ^ srcb[XLEN-1]) : 1'b0;
              if (div0_s) begin
                // Quotient 0, remainder = dividend: DONE's selection yields the zero-divisor results.
                a_r     <= '0;
                b_r     <= '0;
                acc_r   <= srca;
                state_r <= DONE;
              end else begin
                a_r     <= (op == OP_SDIV) ? mag(srca) : srca;
                b_r     <= (op == OP_SDIV) ? mag(srcb) : srcb;
                acc_r   <= '0;
                state_r <= CALC;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          CALC: begin
            a_r     <= step_a_s;
            b_r     <= step_b_s;
            acc_r   <= step_acc_s;
            count_r <= count_r - 5'd1;
            if (count_r == 5'd0) begin
              state_r <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
          DONE: begin
            result_r <= final_s;
            wa3_r    <= rd_r;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign we3    = done_r;
  assign result = result_r;
  assign wa3    = wa3_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case sequences,
// and randomized back-to-back operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  wa3;
  logic        we3;

  int total = 0;
  int bad   = 0;
  int we3bad = 0;

  muldiv_unit #(.XLEN(32), .RADDR(4)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .srca(srca), .srcb(srcb), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .wa3(wa3), .we3(we3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q;
    model = 32'd0;
    case (o)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; model = p[31:0]; end
      2'b01: model = (b == 32'd0) ? 32'd0 : a / b;
      2'b10: begin
        if (b == 32'd0) model = 32'd0;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb;
          model = q[31:0];
        end
      end
      2'b11: model = (b == 32'd0) ? a : a % b;
      default: model = 32'd0;
    endcase
  endfunction

  // Launch one op at the next edge k, then observe maxc edges while scrambling inputs.
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] rd, input int maxc, input bit poke, input int flush_at,
                     output logic [31:0] res, output logic [3:0] wa, output int lat,
                     output int busyc, output int dcnt);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b; rd_in = rd;
    @(posedge clk); #1;
    lat = -1; busyc = 0; dcnt = 0; res = 32'd0; wa = 4'd0;
    for (int i = 1; i <= maxc; i++) begin
      start = poke && (i == 5 || i == 20 || i == 33);
      flush = (i == flush_at);
      op = 2'($urandom_range(0, 3)); srca = $urandom; srcb = $urandom; rd_in = 4'($urandom);
      if (busy) busyc++;
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        if (lat < 0) begin lat = i; res = result; wa = wa3; end
      end
      if (we3 !== done) we3bad++;
    end
    start = 1'b0; flush = 1'b0;
  endtask

  logic [31:0] res, expv;
  logic [3:0]  wa, rdv;
  logic [1:0]  opv;
  logic [31:0] av, bv;
  int          lat, busyc, dcnt, elat;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    srca = 32'd0; srcb = 32'd0; rd_in = 4'd0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_we3", {31'd0, we3}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_wa3", {28'd0, wa3}, 32'd0);
    @(negedge clk); rst = 1'b0;

    tbl[0]  = '{2'b00, 32'd7,          32'd3,          4'd4,  32'd21,         33};
    tbl[1]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   4'd1,  32'h00000001,   33};
    tbl[2]  = '{2'b01, 32'd100,        32'd7,          4'd2,  32'd14,         33};
    tbl[3]  = '{2'b11, 32'd100,        32'd7,          4'd3,  32'd2,          33};
    tbl[4]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          4'd5,  32'hFFFFFFFD,   33};
    tbl[5]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   4'd6,  32'h80000000,   33};
    tbl[6]  = '{2'b10, 32'd7,          32'hFFFFFFFE,   4'd7,  32'hFFFFFFFD,   33};
    tbl[7]  = '{2'b01, 32'd5,          32'd0,          4'd8,  32'd0,          1};
    tbl[8]  = '{2'b11, 32'd5,          32'd0,          4'd9,  32'd5,          1};
    tbl[9]  = '{2'b10, 32'hFFFFFFF8,   32'd0,          4'd10, 32'd0,          1};
    tbl[10] = '{2'b10, 32'hFFFFFFF8,   32'hFFFFFFFD,   4'd11, 32'd2,          33};
    tbl[11] = '{2'b11, 32'h12345678,   32'h00000100,   4'd15, 32'h00000078,   33};

    for (int t = 0; t < 12; t++) begin
      run(tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].rd, 40, (t == 0), 0, res, wa, lat, busyc, dcnt);
      chk($sformatf("vec%0d_result", t), res, tbl[t].exp);
      chk($sformatf("vec%0d_wa3", t), {28'd0, wa}, {28'd0, tbl[t].rd});
      chk($sformatf("vec%0d_latency", t), lat, tbl[t].lat);
      chk($sformatf("vec%0d_busy_cycles", t), busyc, (tbl[t].lat == 1) ? 1 : 33);
      chk($sformatf("vec%0d_done_pulses", t), dcnt, 1);
    end

    // Flush sampled at edge k+10 aborts; a start at edge k+11 then completes normally.
    run(2'b00, 32'd5, 32'd5, 4'd2, 10, 1'b0, 10, res, wa, lat, busyc, dcnt);
    chk("flush_no_done", dcnt, 0);
    chk("flush_busy_low", {31'd0, busy}, 32'd0);
    run(2'b00, 32'd9, 32'd9, 4'd3, 40, 1'b0, 0, res, wa, lat, busyc, dcnt);
    chk("after_flush_result", res, 32'd81);
    chk("after_flush_latency", lat, 33);

    // Flush together with start in IDLE: nothing is latched.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; srca = 32'd3; srcb = 32'd3; rd_in = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("flush_start_no_done", dcnt, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1; op = 2'b00; srca = 32'd11; srcb = 32'd13; rd_in = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst = 1'b1; #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_we3", {31'd0, we3}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    #3; rst = 1'b0;
    dcnt = 0; busyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
      if (busy) busyc++;
    end
    chk("post_rst_idle_busy", busyc, 0);
    chk("post_rst_idle_done", dcnt, 0);
    run(2'b00, 32'd6, 32'd6, 4'd12, 40, 1'b0, 0, res, wa, lat, busyc, dcnt);
    chk("post_rst_mul_result", res, 32'd36);
    chk("post_rst_mul_latency", lat, 33);

    // Randomized back-to-back operations (next start sampled at edge k+34).
    for (int n = 0; n < 60; n++) begin
      opv = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: begin av = $urandom; bv = 32'd0; end
        1: begin av = $urandom; bv = $urandom_range(1, 20); end
        2: begin av = $urandom_range(0, 1000); bv = $urandom_range(0, 1000); end
        3: begin av = $urandom; bv = ~($urandom_range(0, 9)); end
        default: begin av = $urandom; bv = $urandom; end
      endcase
      rdv = 4'($urandom);
      expv = model(opv, av, bv);
      elat = (opv != 2'b00 && bv == 32'd0) ? 1 : 33;
      run(opv, av, bv, rdv, 33, 1'b0, 0, res, wa, lat, busyc, dcnt);
      chk($sformatf("rnd%0d_op%0d_%h_%h_result", n, opv, av, bv), res, expv);
      chk($sformatf("rnd%0d_wa3", n), {28'd0, wa}, {28'd0, rdv});
      chk($sformatf("rnd%0d_latency", n), lat, elat);
      chk($sformatf("rnd%0d_done_pulses", n), dcnt, 1);
    end

    chk("we3_tracks_done", we3bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
